// File: rtl/hazard_control.sv
// Pipeline hazard controller: load-use stalls, branch flushes, data-memory wait
// freezes with a timeout fault, and a saturating stall-cycle counter.
module hazard_control #(
    parameter logic [7:0] TIMEOUT = 8'd200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ifidRS,
    input  logic [4:0]  ifidRT,
    input  logic [2:0]  ifidInstrType,
    input  logic [2:0]  idexInstrType,
    input  logic [4:0]  idex_wba,
    input  logic [2:0]  exmemInstrType,
    input  logic        branchTaken,
    input  logic        memAck,
    output logic        pcEn,
    output logic        ifidEn,
    output logic        idexEn,
    output logic        exmemEn,
    output logic        ifidFlush,
    output logic        idexFlush,
    output logic        memwbFlush,
    output logic        memReq,
    output logic        memFault,
    output logic [15:0] stallCycles
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned STALL_W = 16;

    typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT, FAULT} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   to_cnt_q, to_cnt_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    logic mem_op_c, mem_req_c, mem_wait_c, load_use_c;

    // Hazard detection from the ID/EX/MEM instruction fields
    always_comb begin
        mem_op_c   = (exmemInstrType == 3'd2) || (exmemInstrType == 3'd3);
        mem_req_c  = mem_op_c && ((state_q == RUN) || (state_q == MEM_WAIT));
        mem_wait_c = mem_req_c && !memAck;
        load_use_c = (idexInstrType == 3'd2) && (idex_wba != 5'd0) &&
                     (((idex_wba == ifidRS) && (ifidInstrType <= 3'd3)) ||
                      ((idex_wba == ifidRT) &&
                       ((ifidInstrType == 3'd0) || (ifidInstrType == 3'd3))));
    end

    // Next state, timeout count and stage-control outputs
    always_comb begin
        state_d    = state_q;
        to_cnt_d   = to_cnt_q;
        pcEn       = 1'b1;
        ifidEn     = 1'b1;
        idexEn     = 1'b1;
        exmemEn    = 1'b1;
        ifidFlush  = 1'b0;
        idexFlush  = 1'b0;
        memwbFlush = 1'b0;
        memReq     = mem_req_c;
        memFault   = 1'b0;

        if (state_q == FAULT) begin
            pcEn       = 1'b0;
            ifidEn     = 1'b0;
            idexEn     = 1'b0;
            exmemEn    = 1'b0;
            ifidFlush  = 1'b1;
            idexFlush  = 1'b1;
            memwbFlush = 1'b1;
            memFault   = 1'b1;
        end else if (mem_wait_c) begin
            pcEn       = 1'b0;
            ifidEn     = 1'b0;
            idexEn     = 1'b0;
            exmemEn    = 1'b0;
            memwbFlush = 1'b1;
            if (state_q == MEM_WAIT) begin
                if (to_cnt_q == TIMEOUT - 8'd1) begin
                    state_d = FAULT;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
            end else begin
                state_d  = MEM_WAIT;
                to_cnt_d = '0;
            end
        end else if (branchTaken) begin
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
            state_d   = RUN;
        end else if (load_use_c && (state_q == RUN)) begin
            pcEn      = 1'b0;
            ifidEn    = 1'b0;
            idexFlush = 1'b1;
            state_d   = LU_STALL;
        end else begin
            state_d = RUN;
        end

        // Reset holds the pipeline frozen with bubbles everywhere
        if (!rst_n) begin
            pcEn       = 1'b0;
            ifidEn     = 1'b0;
            idexEn     = 1'b0;
            exmemEn    = 1'b0;
            ifidFlush  = 1'b1;
            idexFlush  = 1'b1;
            memwbFlush = 1'b1;
            memReq     = 1'b0;
            memFault   = 1'b0;
        end

        stall_d = stall_q;
        if (!pcEn && (state_q != FAULT) && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    assign stallCycles = stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            to_cnt_q <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            stall_q  <= stall_d;
        end
    end

endmodule

// File: tb/tb_hazard_control.sv
// Bench for hazard_control: constant vector table, hand sequences for the
// multi-cycle cases, and randomized traffic against a behavioural model.
module tb_hazard_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs, rt, wba;
    logic [2:0]  it, xt, mt;
    logic        br, ack;

    logic        pc0, fe0, de0, ee0, ff0, df0, mf0, rq0, ft0;
    logic        pc1, fe1, de1, ee1, ff1, df1, mf1, rq1, ft1;
    logic [15:0] st0, st1;
    logic [8:0]  out0, out1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_control dut (
        .clk(clk), .rst_n(rst_n), .ifidRS(rs), .ifidRT(rt), .ifidInstrType(it),
        .idexInstrType(xt), .idex_wba(wba), .exmemInstrType(mt),
        .branchTaken(br), .memAck(ack),
        .pcEn(pc0), .ifidEn(fe0), .idexEn(de0), .exmemEn(ee0),
        .ifidFlush(ff0), .idexFlush(df0), .memwbFlush(mf0),
        .memReq(rq0), .memFault(ft0), .stallCycles(st0)
    );

    hazard_control #(.TIMEOUT(8'd4)) dut_t4 (
        .clk(clk), .rst_n(rst_n), .ifidRS(rs), .ifidRT(rt), .ifidInstrType(it),
        .idexInstrType(xt), .idex_wba(wba), .exmemInstrType(mt),
        .branchTaken(br), .memAck(ack),
        .pcEn(pc1), .ifidEn(fe1), .idexEn(de1), .exmemEn(ee1),
        .ifidFlush(ff1), .idexFlush(df1), .memwbFlush(mf1),
        .memReq(rq1), .memFault(ft1), .stallCycles(st1)
    );

    assign out0 = {pc0, fe0, de0, ee0, ff0, df0, mf0, rq0, ft0};
    assign out1 = {pc1, fe1, de1, ee1, ff1, df1, mf1, rq1, ft1};

    // Output vectors: {pcEn,ifidEn,idexEn,exmemEn, ifidF,idexF,memwbF, memReq, memFault}
    localparam logic [8:0] V_RST    = 9'b0000_111_0_0;
    localparam logic [8:0] V_FAULT  = 9'b0000_111_0_1;
    localparam logic [8:0] V_FREEZE = 9'b0000_001_1_0;
    localparam logic [8:0] V_NORM   = 9'b1111_000_0_0;
    localparam logic [8:0] V_NORMRQ = 9'b1111_000_1_0;
    localparam logic [8:0] V_LU     = 9'b0011_010_0_0;
    localparam logic [8:0] V_BR     = 9'b1111_110_0_0;
    localparam logic [8:0] V_BRRQ   = 9'b1111_110_1_0;

    typedef struct {
        logic [4:0] rs, rt;
        logic [2:0] it, xt;
        logic [4:0] wba;
        logic [2:0] mt;
        logic       br, ack;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[13];

    // Behavioural model: one set of pipeline-controller facts per instance
    bit m_fault[2], m_wait[2], m_lu[2];
    int m_cnt[2], m_stall[2];
    int m_to[2] = '{200, 4};

    function automatic bit hazard();
        bit rs_used, rt_used;
        rs_used = (it <= 3'd3);
        rt_used = (it == 3'd0) || (it == 3'd3);
        return (xt == 3'd2) && (wba != 5'd0) &&
               (((wba == rs) && rs_used) || ((wba == rt) && rt_used));
    endfunction

    function automatic logic [8:0] model_out(int i);
        bit req;
        if (!rst_n) return V_RST;
        if (m_fault[i]) return V_FAULT;
        req = ((mt == 3'd2) || (mt == 3'd3)) && !m_lu[i];
        if (req && !ack) return V_FREEZE;
        if (br) return {4'b1111, 3'b110, req, 1'b0};
        if (hazard() && !m_wait[i] && !m_lu[i]) return {4'b0011, 3'b010, req, 1'b0};
        return {4'b1111, 3'b000, req, 1'b0};
    endfunction

    task automatic model_step(int i);
        logic [8:0] o;
        bit req;
        o = model_out(i);
        if (!rst_n) begin
            m_fault[i] = 0; m_wait[i] = 0; m_lu[i] = 0; m_cnt[i] = 0; m_stall[i] = 0;
            return;
        end
        if (m_fault[i]) return;
        if (!o[8] && m_stall[i] < 65535) m_stall[i]++;
        req = ((mt == 3'd2) || (mt == 3'd3)) && !m_lu[i];
        if (req && !ack) begin
            if (m_wait[i]) begin
                if (m_cnt[i] == m_to[i] - 1) m_fault[i] = 1;
                else m_cnt[i]++;
            end else begin
                m_wait[i] = 1;
                m_cnt[i] = 0;
            end
            m_lu[i] = 0;
        end else if (!br && hazard() && !m_wait[i] && !m_lu[i]) begin
            m_lu[i] = 1;
        end else begin
            m_wait[i] = 0;
            m_lu[i] = 0;
        end
    endtask

    function automatic logic [8:0] get_out(int i);
        return (i == 0) ? out0 : out1;
    endfunction

    function automatic logic [15:0] get_st(int i);
        return (i == 0) ? st0 : st1;
    endfunction

    task automatic chk(string name, logic [15:0] got, logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(logic [4:0] a, logic [4:0] b, logic [2:0] c, logic [2:0] d,
                          logic [4:0] e, logic [2:0] f, logic g, logic h);
        rs = a; rt = b; it = c; xt = d; wba = e; mt = f; br = g; ack = h;
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        #1;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic model_cycle(string tag);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_out"}, 16'(get_out(i)), 16'(model_out(i)));
            chk({tag, "_stall"}, get_st(i), rst_n ? 16'(m_stall[i]) : 16'd0);
        end
        tick();
    endtask

    initial begin
        tbl[0]  = '{5'd0, 5'd0, 3'd0, 3'd0, 5'd0, 3'd0, 1'b0, 1'b0, V_NORM};
        tbl[1]  = '{5'd0, 5'd5, 3'd0, 3'd2, 5'd5, 3'd0, 1'b0, 1'b0, V_LU};
        tbl[2]  = '{5'd5, 5'd0, 3'd2, 3'd2, 5'd5, 3'd0, 1'b0, 1'b0, V_LU};
        tbl[3]  = '{5'd0, 5'd5, 3'd1, 3'd2, 5'd5, 3'd0, 1'b0, 1'b0, V_NORM};
        tbl[4]  = '{5'd0, 5'd0, 3'd0, 3'd2, 5'd0, 3'd0, 1'b0, 1'b0, V_NORM};
        tbl[5]  = '{5'd5, 5'd5, 3'd0, 3'd3, 5'd5, 3'd0, 1'b0, 1'b0, V_NORM};
        tbl[6]  = '{5'd1, 5'd7, 3'd3, 3'd2, 5'd7, 3'd0, 1'b0, 1'b0, V_LU};
        tbl[7]  = '{5'd7, 5'd7, 3'd6, 3'd2, 5'd7, 3'd0, 1'b0, 1'b0, V_NORM};
        tbl[8]  = '{5'd0, 5'd5, 3'd0, 3'd2, 5'd5, 3'd0, 1'b1, 1'b0, V_BR};
        tbl[9]  = '{5'd0, 5'd0, 3'd0, 3'd0, 5'd0, 3'd2, 1'b1, 1'b0, V_FREEZE};
        tbl[10] = '{5'd0, 5'd0, 3'd0, 3'd0, 5'd0, 3'd3, 1'b0, 1'b1, V_NORMRQ};
        tbl[11] = '{5'd0, 5'd5, 3'd0, 3'd2, 5'd5, 3'd2, 1'b0, 1'b0, V_FREEZE};
        tbl[12] = '{5'd0, 5'd0, 3'd0, 3'd0, 5'd0, 3'd2, 1'b1, 1'b1, V_BRRQ};

        rst_n = 1'b0;
        set_in(5'd0, 5'd0, 3'd0, 3'd0, 5'd0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("reset_out0", 16'(out0), 16'(V_RST));
        chk("reset_out1", 16'(out1), 16'(V_RST));
        chk("reset_stall0", st0, 16'd0);
        tick();
        rst_n = 1'b1;

        // Single-cycle decisions taken from a fresh RUN state
        for (int k = 0; k < 13; k++) begin
            rst_pulse();
            set_in(tbl[k].rs, tbl[k].rt, tbl[k].it, tbl[k].xt, tbl[k].wba,
                   tbl[k].mt, tbl[k].br, tbl[k].ack);
            #1;
            chk($sformatf("vec%0d_dut", k), 16'(out0), 16'(tbl[k].exp));
            chk($sformatf("vec%0d_t4", k), 16'(out1), 16'(tbl[k].exp));
            tick();
        end

        // Load-use: one stall, then released while inputs are held
        rst_pulse();
        set_in(5'd0, 5'd5, 3'd0, 3'd2, 5'd5, 3'd0, 1'b0, 1'b0);
        #1;
        chk("lu_stall", 16'(out0), 16'(V_LU));
        tick();
        #1;
        chk("lu_release", 16'(out0), 16'(V_NORM));
        chk("lu_stallcnt", st0, 16'd1);
        tick();

        // Store waits three cycles for the memory acknowledge
        rst_pulse();
        set_in(5'd0, 5'd0, 3'd0, 3'd0, 5'd0, 3'd3, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("memw_freeze%0d", k), 16'(out0), 16'(V_FREEZE));
            tick();
        end
        ack = 1'b1;
        #1;
        chk("memw_ack", 16'(out0), 16'(V_NORMRQ));
        tick();
        set_in(5'd0, 5'd5, 3'd0, 3'd2, 5'd5, 3'd0, 1'b0, 1'b0);
        #1;
        chk("memw_stallcnt", st0, 16'd3);
        chk("memw_back_run", 16'(out0), 16'(V_LU));
        tick();

        // Timeout of 4 on the second instance, then reset recovery
        rst_pulse();
        set_in(5'd0, 5'd0, 3'd0, 3'd0, 5'd0, 3'd2, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("to4_wait%0d", k), 16'(out1), 16'(V_FREEZE));
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("to4_fault%0d", k), 16'(out1), 16'(V_FAULT));
            chk($sformatf("to4_stall%0d", k), st1, 16'd5);
            chk($sformatf("to4_dflt_wait%0d", k), 16'(out0), 16'(V_FREEZE));
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk("to4_rst_out", 16'(out1), 16'(V_RST));
        tick();
        rst_n = 1'b1;
        ack = 1'b1;
        #1;
        chk("to4_after_rst", 16'(out1), 16'(V_NORMRQ));
        tick();

        // Default timeout of 200 cycles in MEM_WAIT
        ack = 1'b0;
        for (int k = 0; k < 201; k++) begin
            if (k == 200) begin
                #1;
                chk("to200_last_wait", 16'(out0), 16'(V_FREEZE));
            end
            tick();
        end
        #1;
        chk("to200_fault", 16'(out0), 16'(V_FAULT));
        chk("to200_stall", st0, 16'd201);

        // Saturation: 200 stalls per round, acknowledged just before timeout
        rst_pulse();
        set_in(5'd0, 5'd0, 3'd0, 3'd0, 5'd0, 3'd2, 1'b0, 1'b0);
        for (int r = 1; r <= 328; r++) begin
            ack = 1'b0;
            for (int k = 0; k < 200; k++) tick();
            ack = 1'b1;
            tick();
            if (r == 327) begin
                #1;
                chk("sat_pre", st0, 16'd65400);
            end
        end
        #1;
        chk("sat_stall", st0, 16'hFFFF);
        chk("sat_model", st0, 16'(m_stall[0]));
        chk("sat_nofault", 16'(ft0), 16'd0);
        tick();

        // Randomized traffic against the behavioural model
        rst_pulse();
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   5'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1));
            model_cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_control.md
HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8'd200, max cycles in MEM_WAIT before fault.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports ifidRS, ifidRT  input  5 each  source registers of instruction in ID.
REQ-005 SHALL have port ifidInstrType  input  3  type of ID instruction (0 RegReg ALU, 1 ALUimm, 2 Load, 3 Store, 6/7 pp move).
REQ-006 SHALL have ports idexInstrType  input  3 and idex_wba  input  5  type and destination of EX instruction.
REQ-007 SHALL have port exmemInstrType  input  3  type of MEM instruction.
REQ-008 SHALL have ports branchTaken  input  1 (EX resolved taken branch) and memAck  input  1 (data memory done).
REQ-009 SHALL have outputs pcEn, ifidEn, idexEn, exmemEn  1 each  stage register enables.
REQ-010 SHALL have outputs ifidFlush, idexFlush, memwbFlush  1 each  insert bubble into that register.
REQ-011 SHALL have outputs memReq  1, memFault  1, stallCycles  16  (memory request, sticky timeout fault, stall counter).

Function
REQ-012 SHALL implement FSM states RUN, LU_STALL, MEM_WAIT, FAULT, registered; encoding free.
REQ-013 memReq SHALL equal (exmemInstrType is 2 or 3) AND state is RUN or MEM_WAIT, combinationally.
REQ-014 memWait condition SHALL be memReq AND NOT memAck.
REQ-015 Load-use SHALL be: idexInstrType==2, idex_wba!=0, and (idex_wba==ifidRS with ifidInstrType in {0,1,2,3}, or idex_wba==ifidRT with ifidInstrType in {0,3}).
REQ-016 Priority SHALL be FAULT > memWait > branchTaken > load-use > normal.
REQ-017 Normal (RUN/LU_STALL, no event): all enables 1, all flushes 0.
REQ-018 memWait (same cycle, RUN or MEM_WAIT): pcEn, ifidEn, idexEn, exmemEn = 0; memwbFlush=1; other flushes 0; next state MEM_WAIT.
REQ-019 MEM_WAIT with memAck=1: outputs per normal rules; next state RUN.
REQ-020 Timeout counter (8 bit) SHALL clear on entry to MEM_WAIT, increment each MEM_WAIT cycle with memAck=0; memWait while count==TIMEOUT-1 SHALL move to FAULT next edge.
REQ-021 branchTaken (no memWait): pcEn=1, ifidFlush=1, idexFlush=1, other enables 1; next state RUN; load-use ignored.
REQ-022 Load-use in RUN (no higher event): pcEn=0, ifidEn=0, idexFlush=1, idexEn=1, exmemEn=1; next state LU_STALL.
REQ-023 LU_STALL SHALL suppress load-use detection for one cycle, then return to RUN (unless memWait/branch rules move it).
REQ-024 FAULT SHALL be sticky until reset: all enables 0, all flushes 1, memReq 0, memFault 1.
REQ-025 stallCycles SHALL increment by 1 each edge where pcEn==0 and state!=FAULT, saturating at 16'hFFFF (no wrap).

Reset
REQ-026 While rst_n=0: state RUN, timeout counter 0, stallCycles 0, all enables 0, all flushes 1, memReq 0, memFault 0.
REQ-027 Reset assertion mid MEM_WAIT or FAULT SHALL return to RUN immediately and clear memFault; first edge after release behaves as RUN.

Verification
REQ-028 Load-use: idexInstrType=2, idex_wba=5, ifidInstrType=0, ifidRT=5 -> one cycle pcEn=0, ifidEn=0, idexFlush=1; next cycle (inputs held) all enables 1; stallCycles=1.
REQ-029 idex_wba=0 with ifidRS=0, idexInstrType=2 -> no stall; ifidInstrType=1, ifidRT match -> no stall.
REQ-030 exmemInstrType=3, memAck low 3 cycles then high -> memReq=1 4 cycles, freeze + memwbFlush 3 cycles, state RUN after ack, stallCycles=3.
REQ-031 branchTaken=1 with simultaneous load-use -> ifidFlush=1, idexFlush=1, pcEn=1, no stall; with simultaneous memWait -> freeze wins, no flush.
REQ-032 TIMEOUT=4, memAck held 0 -> FAULT after 4 wait cycles, memFault=1 held, memReq=0; rst_n pulse low -> memFault=0, state RUN.
REQ-033 Force 65540 stall cycles -> stallCycles stops at 16'hFFFF.
